mul163_seq_ctrl: RTL and testbench

// - Sequencer for the digit-serial systolic GF(2^163) multiplier (digit size 8).
// - Accepts a start/ack handshake from the host and drives the datapath strobes:
//   - operand load, accumulator clear, per-digit shift/accumulate, digit index.
// - Waits out the systolic pipeline drain, then holds the result-valid flag until acknowledged.
// - Sits between the host/ALU front end and the multiplier array; owns no datapath bits itself.
//

---
 rtl/mul163_pkg.sv | 19 +
 rtl/mul163_seq_ctrl_if.sv | 30 +++
 rtl/mul163_dig_cnt.sv | 36 +++
 rtl/mul163_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_mul163_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul163_pkg.sv
// Shared definitions for the GF(2^163) digit-serial multiplier sequencer.
// Holds the default field/digit/pipeline parameters and the FSM state encoding.
package mul163_pkg;

  localparam int DEF_M    = 163;                          // field degree
  localparam int DEF_D    = 8;                            // digit width
  localparam int DEF_NDIG = (DEF_M + DEF_D - 1) / DEF_D;  // 21 digits
  localparam int DEF_PIPE = 2;                            // systolic drain cycles
  localparam int DEF_CW   = 5;                            // digit counter width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mul163_seq_ctrl_if.sv
// Host/datapath handshake bundle of the multiplier sequencer.
//   start, ack, abort          : host requests (driven by master)
//   ready, busy, done          : sequencer status
//   ld_op, acc_clr, shift_en,
//   acc_en, digit_idx          : datapath strobes and current digit
interface mul163_seq_ctrl_if #(
  parameter int CW = 5
);
  logic          start;
  logic          ack;
  logic          abort;
  logic          ready;
  logic          busy;
  logic          ld_op;
  logic          acc_clr;
  logic          shift_en;
  logic          acc_en;
  logic [CW-1:0] digit_idx;
  logic          done;

  modport master (
    output start, ack, abort,
    input  ready, busy, ld_op, acc_clr, shift_en, acc_en, digit_idx, done
  );

  modport slave (
    input  start, ack, abort,
    output ready, busy, ld_op, acc_clr, shift_en, acc_en, digit_idx, done
  );
endinterface

// File: rtl/mul163_dig_cnt.sv
// CW-bit down counter shared by the RUN (digit index) and DRAIN phases.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : synchronous clear (highest priority after reset)
//   load      : load load_val
//   dec       : decrement by one
//   cnt, zero : current count and cnt==0 flag
module mul163_dig_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mul163_seq_ctrl.sv
// Sequencer for the digit-serial systolic GF(2^163) multiplier.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : slave side of the host/datapath bundle (see mul163_seq_ctrl_if)
// Flow: IDLE -> LOAD (1 cycle) -> RUN (NDIG cycles, MSD first)
//       -> DRAIN (PIPE cycles, skipped when PIPE==0) -> DONE (until ack).
// All outputs are decoded from the registered state and counter only.
module mul163_seq_ctrl
  import mul163_pkg::*;
#(
  parameter int NDIG = DEF_NDIG,
  parameter int PIPE = DEF_PIPE,
  parameter int CW   = DEF_CW
) (
  input  logic              clk,
  input  logic              rstn,
  mul163_seq_ctrl_if.slave  bus
);

  localparam logic [CW-1:0] RUN_INIT   = CW'(NDIG - 1);
  localparam logic [CW-1:0] DRAIN_INIT = CW'((PIPE > 0) ? PIPE - 1 : 0);

  state_t        state, state_n;
  logic          cnt_clr, cnt_load, cnt_dec;
  logic [CW-1:0] cnt_val, cnt;
  logic          cnt_zero;

  mul163_dig_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state and counter control. abort wins over start/ack everywhere;
  // in IDLE it simply keeps the sequencer from leaving.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    state_n  = state;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          state_n  = ST_RUN;
          cnt_load = 1'b1;
          cnt_val  = RUN_INIT;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          if (PIPE == 0) begin
            state_n = ST_DONE;
          end else begin
            state_n  = ST_DRAIN;
            cnt_load = 1'b1;
            cnt_val  = DRAIN_INIT;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          state_n = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (bus.ack) begin
          // ack together with start restarts without an IDLE bubble.
          state_n = bus.start ? ST_LOAD : ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    bus.ready     = 1'b0;
    bus.busy      = 1'b0;
    bus.ld_op     = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.shift_en  = 1'b0;
    bus.acc_en    = 1'b0;
    bus.digit_idx = '0;
    bus.done      = 1'b0;
    unique case (state)
      ST_IDLE:  bus.ready = 1'b1;
      ST_LOAD: begin
        bus.busy    = 1'b1;
        bus.ld_op   = 1'b1;
        bus.acc_clr = 1'b1;
      end
      ST_RUN: begin
        bus.busy      = 1'b1;
        bus.shift_en  = 1'b1;
        bus.acc_en    = 1'b1;
        bus.digit_idx = cnt;
      end
      ST_DRAIN: begin
        bus.busy   = 1'b1;
        bus.acc_en = 1'b1;
      end
      ST_DONE:  bus.done = 1'b1;
      default:  bus.ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mul163_seq_ctrl.sv
// Self-checking bench for mul163_seq_ctrl: a default instance (NDIG=21,
// PIPE=2) and a variant (NDIG=3, PIPE=0) share the same host inputs. A
// schedule-based model (operation phase + elapsed cycles) predicts every
// output on every cycle; directed tests pin the model with literal values.
module tb_mul163_seq_ctrl;

  logic clk = 1'b0;
  logic rstn, start, ack, abort;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul163_seq_ctrl_if #(.CW(5)) bus0 ();
  mul163_seq_ctrl_if #(.CW(5)) bus1 ();

  assign bus0.start = start;
  assign bus0.ack   = ack;
  assign bus0.abort = abort;
  assign bus1.start = start;
  assign bus1.ack   = ack;
  assign bus1.abort = abort;

  mul163_seq_ctrl dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
  mul163_seq_ctrl #(.NDIG(3), .PIPE(0), .CW(5)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  // Observed outputs packed as {ready,busy,ld_op,acc_clr,shift_en,acc_en,done,idx[4:0]}.
  logic [11:0] obs0, obs1;
  assign obs0 = {bus0.ready, bus0.busy, bus0.ld_op, bus0.acc_clr, bus0.shift_en,
                 bus0.acc_en, bus0.done, bus0.digit_idx};
  assign obs1 = {bus1.ready, bus1.busy, bus1.ld_op, bus1.acc_clr, bus1.shift_en,
                 bus1.acc_en, bus1.done, bus1.digit_idx};

  localparam logic [11:0] P_IDLE  = 12'h800;
  localparam logic [11:0] P_LOAD  = 12'h700;
  localparam logic [11:0] P_RUN   = 12'h4C0;  // OR in the digit index
  localparam logic [11:0] P_DRAIN = 12'h440;
  localparam logic [11:0] P_DONE  = 12'h020;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An operation is either absent, in progress (k cycles since its LOAD
  // cycle), or finished and waiting for ack.
  typedef struct packed {
    logic busy;
    logic done;
    int   k;
  } model_t;

  model_t m0 = '0;
  model_t m1 = '0;
  logic   model_valid = 1'b0;

  function automatic model_t model_next(model_t m, int nd, int pp);
    model_t n = m;
    if (!rstn) begin
      n = '0;
    end else if (m.busy) begin
      if (abort)              n = '0;
      else if (m.k == nd + pp) begin n.busy = 1'b0; n.done = 1'b1; n.k = 0; end
      else                    n.k = m.k + 1;
    end else if (m.done) begin
      if (abort) n = '0;
      else if (ack) begin
        n.done = 1'b0;
        if (start) begin n.busy = 1'b1; n.k = 0; end
      end
    end else if (start && !abort) begin
      n.busy = 1'b1;
      n.k    = 0;
    end
    return n;
  endfunction

  function automatic logic [11:0] model_out(model_t m, int nd);
    logic       run = m.busy && (m.k >= 1) && (m.k <= nd);
    logic [4:0] idx = run ? 5'(nd - m.k) : 5'd0;
    logic       ld  = m.busy && (m.k == 0);
    return {!m.busy && !m.done, m.busy, ld, ld, run, m.busy && (m.k >= 1), m.done, idx};
  endfunction

  always @(posedge clk) begin
    m0 <= model_next(m0, 21, 2);
    m1 <= model_next(m1, 3, 0);
    if (!rstn) model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_dflt", 32'(obs0), 32'(model_out(m0, 21)));
      check("model_var",  32'(obs1), 32'(model_out(m1, 3)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start from IDLE; return the cycle number (LOAD cycle = 1) in which
  // done first appears on the default instance.
  task automatic start_and_wait(output int n);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!bus0.done && n < 60) begin
      step();
      n++;
    end
    check("done_timeout", 32'(bus0.done), 32'd1);
  endtask

  task automatic ack_done();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic wait_idx(input logic [4:0] idx);
    int g = 0;
    while (!(bus0.shift_en && bus0.digit_idx == idx) && g < 40) begin
      step();
      g++;
    end
    check("wait_idx_timeout", 32'(g < 40), 32'd1);
  endtask

  logic [11:0] rec0 [0:40];
  logic [11:0] rec1 [0:40];

  initial begin
    int n, m, loads, ready_seen, first0, first1;
    rstn = 1'b0; start = 1'b0; ack = 1'b0; abort = 1'b0;
    @(negedge clk);
    step();
    step();
    check("reset_dflt", 32'(obs0), 32'(P_IDLE));
    check("reset_var",  32'(obs1), 32'(P_IDLE));
    rstn = 1'b1;
    step();

    // ---- single operation on both instances ----
    start = 1'b1;
    step();
    start = 1'b0;
    first0 = 0; first1 = 0;
    for (int c = 1; c <= 36; c++) begin
      rec0[c] = obs0;
      rec1[c] = obs1;
      if (bus0.done && first0 == 0) first0 = c;
      if (bus1.done && first1 == 0) first1 = c;
      ack = (c == 34);
      step();
    end
    ack = 1'b0;
    check("single_done_cycle", 32'(first0), 32'd25);
    check("single_load",       32'(rec0[1]),  32'(P_LOAD));
    check("single_idx20",      32'(rec0[2]),  32'(P_RUN | 12'd20));
    check("single_idx8",       32'(rec0[14]), 32'(P_RUN | 12'd8));
    check("single_idx0",       32'(rec0[22]), 32'(P_RUN));
    check("single_drain23",    32'(rec0[23]), 32'(P_DRAIN));
    check("single_drain24",    32'(rec0[24]), 32'(P_DRAIN));
    check("single_done25",     32'(rec0[25]), 32'(P_DONE));
    check("single_done_held",  32'(rec0[34]), 32'(P_DONE));
    check("single_ready_after",32'(rec0[35]), 32'(P_IDLE));
    check("var_done_cycle",    32'(first1), 32'd5);
    check("var_load",          32'(rec1[1]), 32'(P_LOAD));
    check("var_idx2",          32'(rec1[2]), 32'(P_RUN | 12'd2));
    check("var_idx0",          32'(rec1[4]), 32'(P_RUN));
    check("var_no_drain",      32'(rec1[5]), 32'(P_DONE));

    // ---- reset in the middle of RUN ----
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx(5'd12);
    rstn = 1'b0;
    step();
    step();
    check("midrun_reset_dflt", 32'(obs0), 32'(P_IDLE));
    check("midrun_reset_var",  32'(obs1), 32'(P_IDLE));
    rstn = 1'b1;
    start_and_wait(n);
    check("after_reset_latency", 32'(n), 32'd25);
    ack_done();

    // ---- back-to-back restart from DONE ----
    start_and_wait(n);
    ack = 1'b1; start = 1'b1;
    step();
    ack = 1'b0; start = 1'b0;
    check("b2b_load", 32'(obs0), 32'(P_LOAD));
    m = 0; ready_seen = 0;
    while (!bus0.done && m < 60) begin
      step();
      m++;
      if (bus0.ready) ready_seen++;
    end
    check("b2b_gap_from_load", 32'(m), 32'd24);
    check("b2b_no_ready", 32'(ready_seen), 32'd0);
    ack_done();

    // ---- start held high throughout the operation ----
    start = 1'b1;
    step();
    n = 1; loads = 1;
    while (!bus0.done && n < 60) begin
      step();
      n++;
      if (bus0.ld_op) loads++;
    end
    check("spam_latency", 32'(n), 32'd25);
    check("spam_single_load", 32'(loads), 32'd1);
    step();
    check("spam_done_held", 32'(obs0), 32'(P_DONE));
    start = 1'b0;
    ack_done();

    // ---- abort in RUN ----
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx(5'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 32'(obs0), 32'(P_IDLE));
    step();
    check("abort_no_done", 32'(obs0), 32'(P_IDLE));
    start_and_wait(n);
    check("after_abort_latency", 32'(n), 32'd25);
    ack_done();

    // ---- randomized traffic, checked by the model every cycle ----
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 39) == 0);
      rstn  = ($urandom_range(0, 99) != 0);
      step();
    end
    rstn = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
